// File: rtl/frame_check_sequence_checker.sv
// -----------------------------------------------------------------------------
// frame_check_sequence_checker
//
// Receive-side Ethernet FCS checker. Consumes one frame per burst (destination
// address through the 4 FCS bytes), runs the reflected IEEE 802.3 CRC-32 over
// every byte, strips the FCS through a 4-byte delay line and forwards payload
// bytes. One cycle after the final byte a status pulse reports CRC/length
// verdicts and the byte count. The checker then spends one cycle in S_FINISH
// (ready=0) clearing its per-frame state.
//
// Ports:
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   data             received byte
//   data_enable      byte valid, accepted only while ready=1
//   data_last        with data_enable: byte is the final FCS byte
//   ready            checker can accept a byte this cycle
//   out_data         forwarded payload byte (FCS removed)
//   out_enable       one-cycle pulse per forwarded byte
//   out_last         with out_enable: final payload byte of the frame
//   status_valid     one-cycle pulse, status fields below are fresh
//   frame_good       no CRC error and no length error
//   crc_error        CRC residue mismatch
//   length_error     frame length outside MINIMUM..MAXIMUM (inclusive legal)
//   frame_length     bytes in frame including FCS, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module frame_check_sequence_checker #(
  parameter int MINIMUM_FRAME_BYTES = 64,
  parameter int MAXIMUM_FRAME_BYTES = 1518
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  data,
  input  logic        data_enable,
  input  logic        data_last,
  output logic        ready,
  output logic [7:0]  out_data,
  output logic        out_enable,
  output logic        out_last,
  output logic        status_valid,
  output logic        frame_good,
  output logic        crc_error,
  output logic        length_error,
  output logic [15:0] frame_length
);

  typedef enum logic {
    S_RECEIVE,
    S_FINISH
  } state_t;

  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  // Register value left behind when a correct FCS is run through the CRC.
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [15:0] MIN_LEN     = 16'(MINIMUM_FRAME_BYTES);
  localparam logic [15:0] MAX_LEN     = 16'(MAXIMUM_FRAME_BYTES);

  // One byte of the reflected CRC: bits enter LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc_in,
                                           input logic [7:0]  byte_in);
    logic [31:0] c;
    c = crc_in ^ {24'd0, byte_in};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  state_t      state;
  logic [31:0] crc;
  logic [15:0] count;
  logic [7:0]  line [4];     // line[0] newest, line[3] oldest
  logic [3:0]  line_valid;

  logic        accept;
  logic [31:0] crc_next;
  logic [15:0] count_next;
  logic        crc_bad;
  logic        length_bad;

  // NOTE: every signal driven here gets a value before any condition, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    accept     = data_enable && ready;
    crc_next   = crc_byte(crc, data);
    count_next = (count == 16'hFFFF) ? count : count + 16'd1;
    crc_bad    = (crc_next != CRC_RESIDUE);
    length_bad = (count_next < MIN_LEN) || (count_next > MAX_LEN);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_RECEIVE;
      ready        <= 1'b1;
      crc          <= CRC_INIT;
      count        <= 16'd0;
      line_valid   <= 4'd0;
      // NOTE: the delay-line bytes are reset as well; they are few, and this
      // keeps out_data deterministic from the first forwarded byte onward.
      for (int i = 0; i < 4; i++) line[i] <= 8'd0;
      out_data     <= 8'd0;
      out_enable   <= 1'b0;
      out_last     <= 1'b0;
      status_valid <= 1'b0;
      frame_good   <= 1'b0;
      crc_error    <= 1'b0;
      length_error <= 1'b0;
      frame_length <= 16'd0;
    end else begin
      // Pulse outputs drop unless re-asserted below.
      out_enable   <= 1'b0;
      out_last     <= 1'b0;
      status_valid <= 1'b0;

      case (state)
        S_RECEIVE: begin
          if (accept) begin
            crc        <= crc_next;
            count      <= count_next;
            line[0]    <= data;
            for (int i = 1; i < 4; i++) line[i] <= line[i-1];
            line_valid <= {line_valid[2:0], 1'b1};

            // A full line means the oldest byte is at least 4 bytes ahead of
            // the newest, so it cannot be FCS and is forwarded.
            if (&line_valid) begin
              out_data   <= line[3];
              out_enable <= 1'b1;
              out_last   <= data_last;
            end

            if (data_last) begin
              status_valid <= 1'b1;
              frame_length <= count_next;
              crc_error    <= crc_bad;
              length_error <= length_bad;
              frame_good   <= !(crc_bad || length_bad);
              state        <= S_FINISH;
              ready        <= 1'b0;
            end
          end
        end

        S_FINISH: begin
          crc        <= CRC_INIT;
          count      <= 16'd0;
          line_valid <= 4'd0;
          state      <= S_RECEIVE;
          ready      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/frame_check_sequence_checker.md
Name: frame_check_sequence_checker

Overview:
- Receive-side counterpart of the transmit FCS generator.
- Accepts a byte stream of one Ethernet frame (destination address through FCS, preamble/SFD already stripped) and runs the IEEE 802.3 CRC-32 over every byte including the 4 FCS bytes.
- Strips the FCS via a 4-byte delay line and forwards payload bytes downstream.
- Reports per-frame status: CRC good/bad, length violation and byte count. Sits between the MAC receive deserializer and the switch ingress buffer.

Parameters:
MINIMUM_FRAME_BYTES, 64, smallest legal frame length in bytes, FCS included.
MAXIMUM_FRAME_BYTES, 1518, largest legal frame length in bytes, FCS included.

Ports:
clock  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
data  input  8  received byte
data_enable  input  1  byte valid; accepted only when ready=1
data_last  input  1  with data_enable: this byte is the final FCS byte
ready  output  1  block can accept bytes
out_data  output  8  forwarded payload byte (FCS removed)
out_enable  output  1  out_data valid, one-cycle pulse per byte
out_last  output  1  with out_enable: final payload byte of frame
status_valid  output  1  one-cycle pulse: status fields valid
frame_good  output  1  crc_error=0 and length_error=0
crc_error  output  1  CRC residue mismatch
length_error  output  1  frame_length < MINIMUM or > MAXIMUM
frame_length  output  16  bytes received this frame, FCS included, saturating at 16'hFFFF

Behaviour:
- Reset (asynchronous assert, synchronous release): state=S_RECEIVE, CRC register=32'hFFFF_FFFF, byte counter=0, delay line empty.
  - Outputs at reset: ready=1; out_data=0, out_enable=0, out_last=0; status_valid=0, frame_good=0, crc_error=0, length_error=0, frame_length=0.
- CRC: reflected CRC-32, polynomial 32'hEDB88320, bits processed LSB first, 8 bits per accepted byte, init 32'hFFFF_FFFF, no final XOR.
  - Frame is CRC-good iff the register after the data_last byte equals 32'hDEBB20E3.
- Byte counter: increments on each accepted byte; saturates at 16'hFFFF.
- Delay line: 4-entry byte shift register with per-entry valid bits.
  - When an accepted byte finds all 4 entries valid, the oldest entry is registered to out_data with out_enable=1 on the next cycle.
  - Latency: payload byte k appears 1 cycle after input byte k+4 is accepted.
  - Gaps in data_enable stall the line; bytes never emit without a new input byte.
- State S_RECEIVE:
  - ready=1.
  - data_enable with data_last=0: update CRC, count, shift.
  - data_enable with data_last=1: same update, then:
    - The byte shifted out (if any) carries out_last=1.
    - Next cycle: status_valid=1, frame_length=count including this byte, crc_error and length_error from the final CRC/count, frame_good=!(crc_error|length_error).
    - Go to S_FINISH.
- State S_FINISH (exactly 1 cycle):
  - ready=0; data_enable ignored.
  - CRC register re-initialised to all ones, counter cleared, delay-line valid bits cleared.
  - Return to S_RECEIVE.
- status_valid, out_enable and out_last are single-cycle pulses. frame_good, crc_error, length_error and frame_length hold until the next status_valid.
- Frames of 4 bytes or fewer: no out_enable or out_last is produced, but status_valid still fires; such frames always report length_error=1.
- Min/max comparisons are inclusive-legal: length equal to MINIMUM or MAXIMUM is legal.
- Reset mid-frame: partial frame discarded, no status emitted, state as after reset.
- data_last without data_enable: ignored.

Test Plan:
- MINIMUM_FRAME_BYTES=5: bytes 31 32 33 34 35 36 37 38 39 26 39 F4 CB, data_last on CB → out_data 31..39 (9 pulses), out_last on 39, status_valid with frame_good=1, crc_error=0, length_error=0, frame_length=13.
- Same frame with final byte CA → identical payload output; status crc_error=1, frame_good=0, frame_length=13.
- Defaults: 59 zero bytes plus a correct 4-byte FCS (63 bytes) → crc_error=0, length_error=1, frame_good=0, frame_length=63, 59 payload bytes out.
- Scenario-1 frame with random 0–3 idle cycles between bytes → same output bytes and status. Then a 3-byte frame → no out_enable, status_valid with length_error=1, frame_length=3.
- Back-to-back frames with data_enable held high through S_FINISH → byte offered while ready=0 is not counted or forwarded; second frame processed from a clean CRC state.
- reset_n pulsed low after 6 bytes of a frame → all outputs at reset values immediately; next full valid frame reports frame_good=1 with the correct frame_length.
